oam_dma: RTL

//  Game Boy OAM DMA engine; sits directly upstream of the byte-wide memory model.
//  A CPU write to the DMA register (0xFF46) starts a copy of LEN bytes from
//  {src_hi,8'h00} to DST_BASE, one read and one write per byte.

---
 rtl/gb_mem_pkg.sv | 20 ++
 rtl/oam_dma.sv | 115 +++++++++++
 2 files changed

// File: rtl/gb_mem_pkg.sv
// Shared Game Boy memory-map constants and the OAM DMA state encoding.
// Also holds the echo-RAM fold used by the DMA source path.
package gb_mem_pkg;

    localparam logic [15:0] ADDR_DMA = 16'hFF46;
    localparam logic [15:0] ADDR_OAM = 16'hFE00;
    localparam int          OAM_LEN  = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dma_state_t;

    // Echo RAM (0xE000-0xFDFF) aliases WRAM 0x2000 lower.
    function automatic logic [7:0] fold_echo(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the DMA register copies LEN bytes from
// {src_hi,8'h00} to DST_BASE, alternating one read cycle and one write cycle.
module oam_dma
    import gb_mem_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = ADDR_DMA,
    parameter logic [15:0] DST_BASE     = ADDR_OAM,
    parameter int          LEN          = OAM_LEN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  reg_rdata,
    output logic        reg_rdata_oe,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        mem_wdata_oe,
    input  logic [7:0]  mem_rdata
);

    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] byte_buf_q, byte_buf_d;

    logic trigger;
    logic last_byte;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = ({1'b0, count_q} == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 8'h00;
            src_hi_q   <= 8'h00;
            byte_buf_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            src_hi_q   <= src_hi_d;
            byte_buf_q <= byte_buf_d;
        end
    end

    // NOTE: every next-state signal is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        src_hi_d   = src_hi_q;
        byte_buf_d = byte_buf_q;

        unique case (state_q)
            READ: begin
                byte_buf_d = mem_rdata;
                state_d    = WRITE;
            end
            WRITE: begin
                if (last_byte) begin
                    state_d = IDLE;
                    count_d = 8'h00;
                end else begin
                    state_d = READ;
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A register write restarts from byte 0 whatever the engine was doing.
        if (trigger) begin
            src_hi_d = cpu_wdata;
            count_d  = 8'h00;
            state_d  = READ;
        end
    end

    always_comb begin
        dma_active   = 1'b0;
        mem_addr     = 16'h0000;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = 8'h00;
        mem_wdata_oe = 1'b0;

        unique case (state_q)
            READ: begin
                dma_active = 1'b1;
                mem_addr   = {fold_echo(src_hi_q), count_q};
                mem_re     = 1'b1;
            end
            WRITE: begin
                dma_active   = 1'b1;
                mem_addr     = DST_BASE + {8'h00, count_q};
                mem_we       = 1'b1;
                mem_wdata    = byte_buf_q;
                mem_wdata_oe = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_rdata    = src_hi_q;
    assign reg_rdata_oe = cpu_re && (cpu_addr == DMA_REG_ADDR);

endmodule
